// File: rtl/uart_tx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_pkg
// Purpose : Shared constants and helpers for the UART transmit byte buffer.
//           Provides the default data width / depth and a constant-evaluable
//           ceiling-log2 used to size the FIFO pointers.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package uart_tx_fifo_pkg;

  localparam int DEFAULT_WIDTH = 32'd8;
  localparam int DEFAULT_DEPTH = 32'd8;

  // Ceiling log2, usable in parameter context; log2(8) = 3, log2(2) = 1.
  function automatic int log2(input int value);
    int result;
    result = 32'd0;
    while ((32'd1 << result) < value) begin
      result = result + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Purpose : Byte buffer placed directly upstream of the UART transmitter.
//           CPU writes enter over a ready/valid handshake and are presented in
//           order on the transmitter's DataIn/DataInValid/DataInReady
//           handshake, so software can queue up to Depth bytes at once.
// Ports   :
//   i_clk        system clock, all state updates on the rising edge
//   i_rst_n      synchronous active-low reset
//   i_flush      synchronous clear of queue contents
//   i_in_data    byte from CPU side
//   i_in_valid   i_in_data is valid
//   o_in_ready   FIFO can accept a byte this cycle
//   o_out_data   head-of-queue byte (to transmitter DataIn)
//   o_out_valid  head is valid (to transmitter DataInValid)
//   i_out_ready  consumer takes the head (from transmitter DataInReady)
//   o_count      current occupancy, 0..Depth
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int Width = DEFAULT_WIDTH,
  parameter int Depth = DEFAULT_DEPTH
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_flush,
  input  logic [Width-1:0]          i_in_data,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  output logic [Width-1:0]          o_out_data,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [log2(Depth):0]      o_count
);

  localparam int PtrWidth = log2(Depth);

  localparam logic [PtrWidth:0]   FULL_CNT  = (PtrWidth + 1)'(Depth);
  localparam logic [PtrWidth:0]   ZERO_CNT  = (PtrWidth + 1)'(0);
  localparam logic [PtrWidth:0]   ONE_CNT   = (PtrWidth + 1)'(1);
  localparam logic [PtrWidth-1:0] ZERO_PTR  = PtrWidth'(0);
  localparam logic [PtrWidth-1:0] ONE_PTR   = PtrWidth'(1);

  logic [Width-1:0]    r_mem [Depth];
  logic [PtrWidth-1:0] r_rd_ptr;
  logic [PtrWidth-1:0] r_wr_ptr;
  logic [PtrWidth:0]   r_cnt;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  // Full and empty are told apart only by the counter, never by pointer
  // equality. Reset and flush both block pushes; only reset hides the head.
  assign w_in_ready  = i_rst_n & ~i_flush & (r_cnt != FULL_CNT);
  assign w_out_valid = i_rst_n & (r_cnt != ZERO_CNT);
  assign w_push      = i_in_valid & w_in_ready;
  assign w_pop       = w_out_valid & i_out_ready;

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = w_out_valid;
  assign o_out_data  = r_mem[r_rd_ptr];
  assign o_count     = r_cnt;

  // Pointer and occupancy update; reset and flush clear the queue state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_ptr <= ZERO_PTR;
      r_wr_ptr <= ZERO_PTR;
      r_cnt    <= ZERO_CNT;
    end else if (i_flush) begin
      // A pop accepted this cycle is superseded by the clear.
      r_rd_ptr <= ZERO_PTR;
      r_wr_ptr <= ZERO_PTR;
      r_cnt    <= ZERO_CNT;
    end else begin
      // Pointers are PtrWidth bits wide, so Depth-1 -> 0 wraps for free.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ONE_PTR;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ONE_PTR;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + ONE_CNT;
        2'b01:   r_cnt <= r_cnt - ONE_CNT;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage write; contents are deliberately left untouched by reset/flush.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_in_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Purpose : Directed self-checking bench for uart_tx_fifo (Width=8, Depth=8).
//           Inputs change #1 after a rising edge; outputs are sampled once
//           they have settled, well away from the next rising edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] count;

  int checks;
  int errors;

  uart_tx_fifo #(.Width(8), .Depth(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_flush     (flush),
    .i_in_data   (in_data),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_count     (count)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b expected 0", out_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL idle_count: got %0d expected 0", count); end
  endtask

  task automatic test_ordered_drain();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_byte(exp_b[i]);
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL drain_count: got %0d expected 3", count); end
    checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL drain_head: got %h expected 11", out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_b[i]) begin
        errors++; $display("FAIL drain_data[%0d]: got v=%b %h expected v=1 %h", i, out_valid, out_data, exp_b[i]);
      end
      step();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty_valid: got %b expected 0", out_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL drain_empty_count: got %0d expected 0", count); end
  endtask

  task automatic test_full_boundary();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'(i));
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    // Push attempt while full with a simultaneous pop: pop happens, push refused.
    in_valid = 1'b1; in_data = 8'h08; out_ready = 1'b1;
    #1;
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL full_pop_head: got %h expected 00", out_data); end
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_after_pop_count: got %0d expected 7", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop_ready: got %b expected 1", in_ready); end
    push_byte(8'h08);
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_refill_count: got %0d expected 8", count); end
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
        errors++; $display("FAIL full_drain[%0d]: got v=%b %h expected v=1 %h", i, out_valid, out_data, 8'(i));
      end
      step();
    end
    out_ready = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL full_drained_count: got %0d expected 0", count); end
  endtask

  task automatic test_wrap_stream();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'h40 + 8'(i));
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'h44 + 8'(i);
      #1;
      checks++;
      if (out_data !== 8'h40 + 8'(i) || count !== 4'd4) begin
        errors++; $display("FAIL wrap[%0d]: got %h cnt=%0d expected %h cnt=4", i, out_data, count, 8'h40 + 8'(i));
      end
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h54 + 8'(i)) begin
        errors++; $display("FAIL wrap_tail[%0d]: got v=%b %h expected v=1 %h", i, out_valid, out_data, 8'h54 + 8'(i));
      end
      step();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_latency();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_same_cycle: got %b expected 0", out_valid); end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
      errors++; $display("FAIL latency_next_cycle: got v=%b %h expected v=1 5a", out_valid, out_data);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_flush_reset();
    // Flush with a concurrent push attempt and pop.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i));
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_out_valid: got %b expected 1", out_valid); end
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: got %b expected 0", out_valid); end
    step();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_ee_stored: got %0d expected 0", count); end
    // Same again with a one-cycle reset pulse.
    for (int i = 0; i < 5; i++) push_byte(8'h70 + 8'(i));
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hEE;
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rstpulse_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstpulse_empty: got %b expected 0", out_valid); end
    push_byte(8'h77);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h77 || count !== 4'd1) begin
      errors++; $display("FAIL rstpulse_first: got v=%b %h cnt=%0d expected v=1 77 cnt=1", out_valid, out_data, count);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; flush = 1'b0; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_ordered_drain();
    test_full_boundary();
    test_wrap_stream();
    test_latency();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer directly upstream of the UART transmitter.
- Accepts bytes from the CPU/MMIO side over a ready/valid interface.
- Presents them in order to the transmitter's DataIn/DataInValid/DataInReady handshake.
- Decouples bursty CPU writes from the serial line rate, so software can queue up to Depth bytes without polling per byte.

Parameters:
- Width, 8, data bits per entry.
- Depth, 8, number of entries; power of two and at least 2.
- PtrWidth, `log2(Depth)`, pointer width (localparam, derived).

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset; asserted when 0, sampled on the Clock rising edge.
- Flush  in  1  synchronous clear of contents while Reset is deasserted.
- InData  in  Width  byte from CPU side.
- InValid  in  1  InData is valid.
- InReady  out  1  FIFO can accept a byte this cycle.
- OutData  out  Width  head-of-queue byte, to the transmitter's DataIn.
- OutValid  out  1  head is valid, to the transmitter's DataInValid.
- OutReady  in  1  consumer accepts head, from the transmitter's DataInReady.
- Count  out  PtrWidth+1  current occupancy, 0..Depth.

Behaviour:
- Storage: Depth x Width register array; read pointer RdPtr and write pointer WrPtr, each PtrWidth bits; occupancy counter Cnt, PtrWidth+1 bits.
- Push: occurs when InValid & InReady at a rising edge. Writes mem[WrPtr], WrPtr+1 (mod Depth), Cnt+1.
- Pop: occurs when OutValid & OutReady at a rising edge. RdPtr+1 (mod Depth), Cnt-1.
- Outputs:
  - InReady = Reset & ~Flush & (Cnt != Depth).
  - OutValid = Reset & (Cnt != 0).
  - OutData = mem[RdPtr], a combinational read of a registered array.
  - Count = Cnt.
- Latency: a byte pushed at edge N is visible (OutValid=1, OutData=byte) after edge N, i.e. on cycle N+1. There is no same-cycle pass-through when empty.
- Simultaneous push and pop (0 < Cnt < Depth): both pointers advance; Cnt unchanged; data ordering preserved.
- Full (Cnt == Depth): InReady=0; the push is refused even if a pop occurs the same cycle. The pop still completes, so InReady=1 next cycle.
- Empty (Cnt == 0): OutValid=0; OutReady is ignored; OutData is don't-care.
- Wrap-around: pointers wrap Depth-1 -> 0 with no bubble. Full and empty are distinguished only by Cnt, not by pointer equality.
- Input holding: InData/InValid are not required to stay stable when InReady=0. The FIFO holds OutData stable while OutValid=1 and no pop occurs.
- Reset (Reset==0 at an edge): RdPtr=0, WrPtr=0, Cnt=0; array contents not cleared.
  - While Reset==0: InReady=0, OutValid=0, Count=0 is reached after the first reset edge.
  - Reset mid-operation discards all queued bytes. A byte partly shifted out by the transmitter is that block's concern; this FIFO simply drops its queue.
- Flush (Reset==1, Flush==1 at an edge): same pointer/count clear as reset.
  - Pushes that cycle are refused (InReady=0).
  - A pop that cycle is permitted (OutValid unaffected) but is superseded by the clear.
- Count width rule: PtrWidth+1 bits so that Depth is representable. All pointer arithmetic is truncated to PtrWidth bits.

Decomposition:
- Shared header util.vh supplies `log2`; no new typedefs.
- Width/Depth defaults live as localparams in the top-level UART wrapper, which instantiates uart_tx_fifo and the transmitter back-to-back (OutData->DataIn, OutValid->DataInValid, DataInReady->OutReady).
- No sub-module; the storage array is small and is inferred in-line.

Test Plan:
- Reset then idle: hold Reset=0 for 3 cycles, release -> InReady=1, OutValid=0, Count=0. While Reset=0, assert InValid with 0xAA -> Count stays 0.
- Ordered drain: push 0x11,0x22,0x33 on consecutive cycles with OutReady=0 -> Count=3 and OutData=0x11. Then OutReady=1 for 3 cycles -> OutData sequence 0x11,0x22,0x33, OutValid=0 after, Count=0.
- Full boundary (Depth=8): push 0x00..0x07 -> Count=8, InReady=0. Push 0x08 with OutReady=1 the same cycle -> 0x00 popped, 0x08 refused, Count=7, InReady=1. Push 0x08 -> later drains as 0x01..0x08.
- Wrap and simultaneous push/pop: preload 4 bytes, then 20 cycles with InValid=OutReady=1 and incrementing data -> Count stays 4; output matches input delayed by exactly 4 accepted transfers across pointer wrap.
- Latency: empty FIFO, push 0x5A at edge N -> OutValid=0 in cycle N, OutValid=1 and OutData=0x5A in cycle N+1.
- Flush / reset mid-operation: preload 5 bytes, pulse Flush one cycle with InValid=1 (0xEE) -> Count=0, OutValid=0, 0xEE not stored. Repeat with Reset=0 one cycle instead -> same result; next push 0x77 emerges first.
